// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line constants.
// Used by uart_tx today and intended for a future uart_rx.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter.
// Circular buffer with pointers one bit wider than the address, so full and
// empty can be told apart without a separate counter register. The head entry
// is presented on rdata combinationally; a push into an empty FIFO becomes
// visible on the following cycle (no bypass path).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_BITS-1:0]   wdata,
    output logic [DATA_BITS-1:0]   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign rdata   = mem[rptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Advance the read and write pointers; both may move in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    // Store the incoming byte; storage needs no reset because pointers guard it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter, LSB first, idle-high line, one line level per
// baud_edge strobe. Bytes are queued in uart_tx_fifo and framed by the FSM.
// Optional feature macro UART_TX_PARITY_EN: when defined, an even parity bit
// is sent between the data bits and the stop bit(s) (8E1/8E2); otherwise the
// frame is 8N1/8N2.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int STOP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   baud_edge,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           bit_idx;
    logic                 stop_cnt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 do_push;
    logic                 do_pop;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign in_ready = !fifo_full;
    assign do_push  = in_valid && in_ready;
    assign do_pop   = (state == IDLE) && baud_edge && !fifo_empty;
    assign busy     = (state != IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Frame sequencer: every state change and every line level is tied to a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= IDLE_LEVEL;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (baud_edge) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg   <= fifo_rdata;
                        tx      <= ~IDLE_LEVEL;
                        bit_idx <= '0;
                        state   <= DATA;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_rdata;
`endif
                    end else begin
                        tx <= IDLE_LEVEL;
                    end
                end
                DATA: begin
                    tx      <= shreg[0];
                    shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end
                PARITY: begin
`ifdef UART_TX_PARITY_EN
                    tx    <= parity_bit;
                    state <= STOP;
`else
                    tx    <= IDLE_LEVEL;
                    state <= IDLE;
`endif
                end
                STOP: begin
                    tx <= IDLE_LEVEL;
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        stop_cnt <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= IDLE_LEVEL;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with directed byte vectors.
// Line bits are captured one per baud_edge and decoded into frames, which are
// compared against frames built from the pushed bytes.
module tb_uart_tx;

    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
    localparam int SB     = 2;
`else
    localparam int PAR_EN = 0;
    localparam int SB     = 1;
`endif
    localparam int FRAME_LEN = 9 + PAR_EN + SB;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_edge;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int          checks = 0;
    int          errors = 0;
    int          baud_cnt = 0;
    logic        line_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] first_frame;
    logic        saw_full = 1'b0;
    int          full_violations = 0;
    int          start_idx;

    uart_tx #(
        .DEPTH     (DEPTH),
        .STOP_BITS (SB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_edge  (baud_edge),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // 100 MHz-style clock with a 10-unit period.
    always #5 clk = ~clk;

    // Baud strobe every 4 clocks, changed on the falling edge.
    initial baud_edge = 1'b0;
    always @(negedge clk) begin
        baud_cnt  = (baud_cnt + 1) % 4;
        baud_edge = (baud_cnt == 0);
    end

    // Capture the line level produced by each strobe, just after the edge.
    always @(posedge clk) begin
        if (baud_edge) begin
            #1;
            line_q.push_back(tx);
        end
    end

    // Track that in_ready is low exactly when the FIFO is full.
    always @(negedge clk) begin
        if (fifo_count == 3'(DEPTH) && in_ready) full_violations++;
        if (fifo_count == 3'(DEPTH) && !in_ready) saw_full = 1'b1;
    end

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one byte and hold it until the posedge that accepts it.
    task automatic applyStimulus(input logic [7:0] d);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("push_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (12) @(negedge clk);
    endtask

    // Leave the negedge right after a strobe posedge.
    task automatic syncToStrobe();
        int n;
        n = 0;
        @(posedge clk);
        while (!baud_edge && n < 16) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] frameBits(input logic [7:0] d);
        logic [31:0] f;
        f      = '0;
        f[8:1] = d;
        if (PAR_EN != 0) f[9] = ^d;
        for (int i = 0; i < SB; i++) f[9 + PAR_EN + i] = 1'b1;
        return f;
    endfunction

    // Decode contiguous frames from the captured line starting at 'start'.
    task automatic checkStream(input string tag, input int start);
        int          p;
        logic [31:0] got;
        logic        trail;
        p = start;
        while (p < line_q.size() && line_q[p] === 1'b1) p++;
        for (int k = 0; k < exp_q.size(); k++) begin
            got = '0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                got[i] = (p + i < line_q.size()) ? line_q[p + i] : 1'bx;
            end
            if (k == 0) first_frame = got;
            checkOutput($sformatf("%s_frame%0d", tag, k), got, frameBits(exp_q[k]));
            p += FRAME_LEN;
        end
        trail = (p < line_q.size()) ? line_q[p] : 1'bx;
        checkOutput({tag, "_trail"}, 32'(trail), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] single byte 0xA5");
        start_idx = line_q.size();
        exp_q = '{8'hA5};
        applyStimulus(8'hA5);
        in_valid = 1'b0;
        checkOutput("a5_busy", 32'(busy), 32'd1);
        waitIdle("a5");
        checkOutput("a5_count", 32'(fifo_count), 32'd0);
        checkStream("a5", start_idx);
`ifdef UART_TX_PARITY_EN
        checkOutput("a5_bits", first_frame, 32'hD4A);
`else
        checkOutput("a5_bits", first_frame, 32'h34A);
`endif

        $display("[TB] fill and backpressure");
        start_idx = line_q.size();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        saw_full = 1'b0;
        full_violations = 0;
        for (int k = 0; k < 6; k++) applyStimulus(exp_q[k]);
        in_valid = 1'b0;
        checkOutput("fill_saw_full", 32'(saw_full), 32'd1);
        waitIdle("fill");
        checkOutput("fill_ready_when_full", 32'(full_violations), 32'd0);
        checkStream("fill", start_idx);

        $display("[TB] simultaneous push and pop");
        syncToStrobe();
        start_idx = line_q.size();
        exp_q = '{8'h5A, 8'hC3, 8'h81, 8'h7E, 8'h0F};
        applyStimulus(8'h5A);
        applyStimulus(8'hC3);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pp_pre_count", 32'(fifo_count), 32'd2);
        applyStimulus(8'h81);
        in_valid = 1'b0;
        checkOutput("pp_count0", 32'(fifo_count), 32'd2);
        for (int k = 3; k < 5; k++) begin
            repeat (4 * FRAME_LEN - 1) @(negedge clk);
            applyStimulus(exp_q[k]);
            in_valid = 1'b0;
            checkOutput($sformatf("pp_count%0d", k - 2), 32'(fifo_count), 32'd2);
        end
        waitIdle("pp");
        checkStream("pp", start_idx);

        $display("[TB] reset in the middle of a frame");
        syncToStrobe();
        applyStimulus(8'hFF);
        applyStimulus(8'hFF);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        checkOutput("mr_pre_busy", 32'(busy), 32'd1);
        checkOutput("mr_pre_count", 32'(fifo_count), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mr_tx", 32'(tx), 32'd1);
        checkOutput("mr_count", 32'(fifo_count), 32'd0);
        checkOutput("mr_busy", 32'(busy), 32'd0);
        checkOutput("mr_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        start_idx = line_q.size();
        exp_q = '{8'h00};
        applyStimulus(8'h00);
        in_valid = 1'b0;
        waitIdle("mr");
        checkStream("mr", start_idx);

        $display("[TB] back-to-back 0x03 frames");
        start_idx = line_q.size();
        exp_q = '{8'h03, 8'h03};
        applyStimulus(8'h03);
        applyStimulus(8'h03);
        in_valid = 1'b0;
        waitIdle("b2b");
        checkStream("b2b", start_idx);
`ifdef UART_TX_PARITY_EN
        checkOutput("b2b_bits", first_frame, 32'hC06);
`else
        checkOutput("b2b_bits", first_frame, 32'h206);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
